// File: rtl/mic_i2s_rx.sv
// mic_i2s_rx: I2S MEMS microphone receiver feeding the audio sample FIFO.
//
// Generates the mic bit clock (mclk) and word select (lr) from clk, deserialises
// the mic data with the I2S one-bit delay, truncates each slot to DAT_WIDTH bits
// and emits one FIFO write per selected slot, suppressed (and flagged) on full.
//
// Build option: define MIC_I2S_RX_STEREO_EN to capture both slots (left then
// right each frame). Without it only slot CHANNEL is captured.
//
// Parameter limits: CLK_DIV >= 4, SLOT_BITS >= 2, 2 <= DAT_WIDTH <= SLOT_BITS-1.
//
// state  | meaning
// IDLE   | stopped; mclk/lr low, counters cleared, waiting for en
// WARMUP | clocks running, samples captured but never written
// RUN    | clocks running, selected slots written to the FIFO

module mic_i2s_rx #(
  parameter int CLK_DIV     = 4,
  parameter int SLOT_BITS   = 32,
  parameter int DAT_WIDTH   = 6,
  parameter int CHANNEL     = 0,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dataint,
  input  logic                 full,
  output logic                 mclk,
  output logic                 lr,
  output logic [DAT_WIDTH-1:0] data_out,
  output logic                 wr,
  output logic                 chan,
  output logic                 overflow,
  output logic                 busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(SLOT_BITS);
  localparam int FW = $clog2(SKIP_FRAMES + 1) + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] SLOT_LAST = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] DAT_IDX   = BW'(DAT_WIDTH);
  localparam logic [FW-1:0] SKIP_CNT  = FW'(SKIP_FRAMES);
  localparam logic          CH_BIT    = (CHANNEL != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t               state;
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [FW-1:0]        frame_cnt;
  logic [FW-1:0]        frame_nxt;
  logic [DAT_WIDTH-1:0] shift_reg;
  logic [DAT_WIDTH-1:0] shift_nxt;
  logic                 din_m;
  logic                 din_s;

  logic run_clk;
  logic div_wrap;
  logic rise_tk;
  logic fall_tk;
  logic slot_wrap;
  logic frame_end;
  logic cap_bit;
  logic slot_sel;
  logic emit;

  // Clocks only run while enabled outside IDLE; dropping en stops them in the
  // same edge that returns the FSM to IDLE, so no partial sample is written.
  assign run_clk   = (state != IDLE) && en;
  assign div_wrap  = (div_cnt == DIV_LAST);
  assign rise_tk   = run_clk && div_wrap && !mclk;
  assign fall_tk   = run_clk && div_wrap && mclk;
  assign slot_wrap = fall_tk && (bit_cnt == SLOT_LAST);
  assign frame_end = slot_wrap && lr;
  assign frame_nxt = frame_cnt + 1'b1;

  // Slot bit 0 is the I2S delay bit; bits above DAT_WIDTH are truncated.
  assign cap_bit   = rise_tk && (bit_cnt != '0) && (bit_cnt <= DAT_IDX);
  assign shift_nxt = {shift_reg[DAT_WIDTH-2:0], din_s};

`ifdef MIC_I2S_RX_STEREO_EN
  assign slot_sel = 1'b1;
`else
  assign slot_sel = (lr == CH_BIT);
`endif

  // The last kept bit arrives on this rise; the sample goes out on the same edge.
  assign emit = rise_tk && (bit_cnt == DAT_IDX) && slot_sel && (state == RUN);

  // Two-flop synchroniser for the mic data, which is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= dataint;
      din_s <= din_m;
    end
  end

  // Bit-clock divider and slot/word-select timebase.
  always_ff @(posedge clk) begin
    if (reset || !run_clk) begin
      div_cnt <= '0;
      mclk    <= 1'b0;
      bit_cnt <= '0;
      lr      <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) begin
        mclk <= ~mclk;
      end
      if (fall_tk) begin
        bit_cnt <= slot_wrap ? '0 : bit_cnt + 1'b1;
        if (slot_wrap) begin
          lr <= ~lr;
        end
      end
    end
  end

  // Serial-to-parallel shift of the kept bits of each slot, MSB first.
  always_ff @(posedge clk) begin
    if (reset || !run_clk) begin
      shift_reg <= '0;
    end else if (cap_bit) begin
      shift_reg <= shift_nxt;
    end
  end

  // FIFO write strobe, sample/slot hold registers and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr       <= 1'b0;
      data_out <= '0;
      chan     <= CH_BIT;
      overflow <= 1'b0;
    end else begin
      wr <= 1'b0;
      if (emit) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wr       <= 1'b1;
          data_out <= shift_nxt;
          chan     <= lr;
        end
      end
    end
  end

  // Sequencer: warm-up frame counting and run/stop control.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
      busy      <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      frame_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_cnt <= '0;
          busy      <= 1'b1;
          state     <= (SKIP_FRAMES == 0) ? RUN : WARMUP;
        end
        WARMUP: begin
          busy <= 1'b1;
          if (frame_end) begin
            frame_cnt <= frame_nxt;
            if (frame_nxt >= SKIP_CNT) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          busy <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          frame_cnt <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
